// File: rtl/wb_pkg.sv
// Writeback queue shared definitions.
// Holds the request source encodings, the link register index, the default
// queue depth and the packed layout of one pending-write entry.
package wb_pkg;

  // req_src encodings; 2'd3 is reserved and behaves like the ALU source.
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_JAL = 2'd2;
  localparam logic [1:0] SRC_RSV = 2'd3;

  // Jal always links into the return-address register.
  localparam logic [4:0] RA_REG = 5'd31;

  // Default number of pending-write entries.
  localparam int WB_DEPTH = 4;

  // One pending register-file write: 5-bit destination plus 32-bit data.
  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Pending-write FIFO storage for the writeback queue.
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-low reset
//   push, push_entry    - enqueue one entry (ignored while full)
//   pop                 - dequeue the head (ignored while empty)
//   full, empty         - occupancy flags
//   head_entry          - entry at the read pointer
//   entry_valid         - per-slot valid, derived from read pointer and count
//   entry_dst           - per-slot destination register
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output wb_entry_t             head_entry,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [DEPTH-1:0][4:0] entry_dst
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;
  logic [PTR_W-1:0] offset_s;

  assign full   = (count_r == CNT_W'(DEPTH));
  assign empty  = (count_r == {CNT_W{1'b0}});
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign head_entry = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful where entry_valid is set.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    offset_s    = {PTR_W{1'b0}};
    entry_valid = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      offset_s       = PTR_W'(i) - rd_ptr_r;
      entry_valid[i] = ({1'b0, offset_s} < count_r);
    end
  end

  // Expose every slot's destination for the pending-register mask.
  always_comb begin
    entry_dst = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_dst[i] = mem_r[i].dst;
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: buffers register-file writes between producers and a
// register-file write port that may be stalled.
// Ports:
//   clock, reset                 - rising-edge clock, synchronous active-low reset
//   req_valid / req_ready        - request handshake (ready = queue not full)
//   req_src, req_dst             - data source select and destination register
//   alu_result, mem_or_io_data,
//   opcplus4                     - candidate write data
//   wb_hold                      - register-file write port busy this cycle
//   wb_regWrite, wb_dst, wb_data - registered register-file write port
//   pend_mask                    - bit i set while a queued entry targets reg i
module writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_src,
  input  logic [4:0]  req_dst,
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_or_io_data,
  input  logic [31:0] opcplus4,
  input  logic        wb_hold,
  output logic        wb_regWrite,
  output logic [4:0]  wb_dst,
  output logic [31:0] wb_data,
  output logic [31:0] pend_mask
);

  logic                  full_s;
  logic                  empty_s;
  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;
  wb_entry_t             push_entry_s;
  wb_entry_t             head_entry_s;
  logic [DEPTH-1:0]      entry_valid_s;
  logic [DEPTH-1:0][4:0] entry_dst_s;
  logic [31:0]           pend_mask_s;

  // Ready is purely "not full" so a same-cycle pop never opens a slot early.
  assign req_ready = reset && !full_s;
  assign accept_s  = req_valid && req_ready;
  // Writes to r0 complete the handshake but are dropped.
  assign push_s    = accept_s && (push_entry_s.dst != 5'd0);
  assign pop_s     = reset && !empty_s && !wb_hold;

  // Source mux and Jal link-register override.
  always_comb begin
    push_entry_s = '0;
    case (req_src)
      SRC_ALU: begin
        push_entry_s.dst  = req_dst;
        push_entry_s.data = alu_result;
      end
      SRC_MEM: begin
        push_entry_s.dst  = req_dst;
        push_entry_s.data = mem_or_io_data;
      end
      SRC_JAL: begin
        push_entry_s.dst  = RA_REG;
        push_entry_s.data = opcplus4;
      end
      SRC_RSV: begin
        push_entry_s.dst  = req_dst;
        push_entry_s.data = alu_result;
      end
      default: begin
        push_entry_s.dst  = req_dst;
        push_entry_s.data = alu_result;
      end
    endcase
  end

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .full       (full_s),
    .empty      (empty_s),
    .head_entry (head_entry_s),
    .entry_valid(entry_valid_s),
    .entry_dst  (entry_dst_s)
  );

  // Registered write port: pulse on pop, otherwise hold dst/data.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wb_regWrite <= 1'b0;
      wb_dst      <= 5'd0;
      wb_data     <= 32'd0;
    end else if (pop_s) begin
      wb_regWrite <= 1'b1;
      wb_dst      <= head_entry_s.dst;
      wb_data     <= head_entry_s.data;
    end else begin
      wb_regWrite <= 1'b0;
    end
  end

  // OR together the destinations of every live entry; popped entries are gone.
  always_comb begin
    pend_mask_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_mask_s = pend_mask_s |
                    (entry_valid_s[i] ? (32'd1 << entry_dst_s[i]) : 32'd0);
    end
  end

  assign pend_mask = reset ? pend_mask_s : 32'd0;

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_src;
  logic [4:0]  req_dst;
  logic [31:0] alu_result;
  logic [31:0] mem_or_io_data;
  logic [31:0] opcplus4;
  logic        wb_hold;
  logic        wb_regWrite;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic [31:0] pend_mask;

  int checks_r = 0;
  int errors_r = 0;

  writeback_queue #(.DEPTH(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_src       (req_src),
    .req_dst       (req_dst),
    .alu_result    (alu_result),
    .mem_or_io_data(mem_or_io_data),
    .opcplus4      (opcplus4),
    .wb_hold       (wb_hold),
    .wb_regWrite   (wb_regWrite),
    .wb_dst        (wb_dst),
    .wb_data       (wb_data),
    .pend_mask     (pend_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] src, input logic [4:0] dst,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4);
    req_valid      = v;
    req_src        = src;
    req_dst        = dst;
    alu_result     = alu;
    mem_or_io_data = mem;
    opcplus4       = pc4;
  endtask

  initial begin
    reset   = 1'b0;
    wb_hold = 1'b0;
    drive(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    #1;
    check("rst_ready_pre", {31'd0, req_ready}, 32'd0);
    step();
    step();
    check("rst_regwrite", {31'd0, wb_regWrite}, 32'd0);
    check("rst_dst", {27'd0, wb_dst}, 32'd0);
    check("rst_data", wb_data, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_pend", pend_mask, 32'd0);

    // Scenario 1: first edge with reset high accepts; write two edges later.
    reset = 1'b1;
    drive(1'b1, 2'd0, 5'd5, 32'h0000_1234, 32'h1111_1111, 32'h2222_2222);
    #1;
    check("s1_ready", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    check("s1_pend", pend_mask, 32'h0000_0020);
    check("s1_no_bypass", {31'd0, wb_regWrite}, 32'd0);
    step();
    check("s1_we", {31'd0, wb_regWrite}, 32'd1);
    check("s1_dst", {27'd0, wb_dst}, 32'd5);
    check("s1_data", wb_data, 32'h0000_1234);
    check("s1_pend_clr", pend_mask, 32'd0);
    step();
    check("s1_we_off", {31'd0, wb_regWrite}, 32'd0);
    check("s1_hold_data", wb_data, 32'h0000_1234);

    // Scenario 2: Jal forces r31 and selects opcplus4.
    drive(1'b1, 2'd2, 5'd7, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0040_0008);
    step();
    req_valid = 1'b0;
    check("s2_pend", pend_mask, 32'h8000_0000);
    step();
    check("s2_dst", {27'd0, wb_dst}, 32'd31);
    check("s2_data", wb_data, 32'h0040_0008);

    // Memory source and reserved source (behaves as ALU).
    drive(1'b1, 2'd1, 5'd9, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0);
    step();
    drive(1'b1, 2'd3, 5'd12, 32'hA5A5_0003, 32'hCAFE_F00D, 32'h0);
    step();
    req_valid = 1'b0;
    check("mem_dst", {27'd0, wb_dst}, 32'd9);
    check("mem_data", wb_data, 32'hCAFE_F00D);
    step();
    check("rsv_dst", {27'd0, wb_dst}, 32'd12);
    check("rsv_data", wb_data, 32'hA5A5_0003);
    step();

    // Scenario 3: r0 destination is consumed but never written.
    drive(1'b1, 2'd0, 5'd0, 32'h0000_9999, 32'h0, 32'h0);
    #1;
    check("s3_ready", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    check("s3_pend", pend_mask, 32'd0);
    check("s3_we0", {31'd0, wb_regWrite}, 32'd0);
    step();
    check("s3_we1", {31'd0, wb_regWrite}, 32'd0);
    check("s3_dst_hold", {27'd0, wb_dst}, 32'd12);

    // Scenario 4: hold the port and fill the queue.
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 2'd0, 5'(i), 32'h100 + 32'(i), 32'h0, 32'h0);
      #1;
      check("s4_ready", {31'd0, req_ready}, 32'd1);
      step();
    end
    drive(1'b1, 2'd0, 5'd5, 32'h0000_0105, 32'h0, 32'h0);
    check("s4_full", {31'd0, req_ready}, 32'd0);
    step();
    check("s4_full2", {31'd0, req_ready}, 32'd0);
    check("s4_pend", pend_mask, 32'h0000_001E);
    check("s4_held", {31'd0, wb_regWrite}, 32'd0);

    // Scenario 5: release hold while full; pop now, enqueue next edge.
    wb_hold = 1'b0;
    step();
    check("s5_we", {31'd0, wb_regWrite}, 32'd1);
    check("s5_dst1", {27'd0, wb_dst}, 32'd1);
    check("s5_data1", wb_data, 32'h0000_0101);
    check("s5_pend_noenq", pend_mask, 32'h0000_001C);
    check("s5_ready", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    check("s5_dst2", {27'd0, wb_dst}, 32'd2);
    check("s5_pend_enq", pend_mask, 32'h0000_0038);
    for (int i = 3; i <= 5; i++) begin
      step();
      check("s4_order_dst", {27'd0, wb_dst}, 32'(i));
      check("s4_order_data", wb_data, 32'h100 + 32'(i));
      check("s4_order_we", {31'd0, wb_regWrite}, 32'd1);
    end
    step();
    check("s4_drained", {31'd0, wb_regWrite}, 32'd0);
    check("s4_pend_empty", pend_mask, 32'd0);

    // Same destination twice: both written, in order.
    drive(1'b1, 2'd0, 5'd6, 32'h0000_AAAA, 32'h0, 32'h0);
    step();
    drive(1'b1, 2'd0, 5'd6, 32'h0000_BBBB, 32'h0, 32'h0);
    step();
    req_valid = 1'b0;
    check("dup_first", wb_data, 32'h0000_AAAA);
    check("dup_pend", pend_mask, 32'h0000_0040);
    step();
    check("dup_second", wb_data, 32'h0000_BBBB);
    check("dup_we", {31'd0, wb_regWrite}, 32'd1);
    check("dup_pend_clr", pend_mask, 32'd0);
    step();

    // Scenario 6: reset with three queued entries discards them.
    wb_hold = 1'b1;
    for (int i = 10; i <= 12; i++) begin
      drive(1'b1, 2'd0, 5'(i), 32'h200 + 32'(i), 32'h0, 32'h0);
      step();
    end
    req_valid = 1'b0;
    check("s6_pend", pend_mask, 32'h0000_1C00);
    wb_hold = 1'b0;
    reset   = 1'b0;
    #1;
    check("s6_pend_rst", pend_mask, 32'd0);
    check("s6_ready_rst", {31'd0, req_ready}, 32'd0);
    step();
    check("s6_we", {31'd0, wb_regWrite}, 32'd0);
    check("s6_dst", {27'd0, wb_dst}, 32'd0);
    check("s6_data", wb_data, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("s6_no_issue", {31'd0, wb_regWrite}, 32'd0);
      check("s6_pend_after", pend_mask, 32'd0);
    end
    check("s6_ready_after", {31'd0, req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of pending-write queue entries (power of two, 2..16).
REQ-002 The module SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset  in  1  synchronous, active-low reset sampled on the rising edge of clock.
REQ-004 The module SHALL have port req_valid  in  1  producer offers one writeback request.
REQ-005 The module SHALL have port req_ready  out  1  queue accepts a request this cycle.
REQ-006 The module SHALL have port req_src  in  2  data source: 0 ALU, 1 mem/IO, 2 Jal link, 3 reserved.
REQ-007 The module SHALL have port req_dst  in  5  destination register (rt or rd already selected by producer).
REQ-008 The module SHALL have ports alu_result, mem_or_io_data and opcplus4, each  in  32  candidate write data.
REQ-009 The module SHALL have port wb_hold  in  1  register-file write port unavailable this cycle.
REQ-010 The module SHALL have ports wb_regWrite  out  1, wb_dst  out  5 and wb_data  out  32  registered register-file write port.
REQ-011 The module SHALL have port pend_mask  out  32  bit i set while any queued entry targets register i.

Function
REQ-012 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-013 req_ready SHALL equal (queue not full), independent of same-cycle dequeue.
REQ-014 At acceptance, data SHALL be selected: src 0 or 3 -> alu_result, src 1 -> mem_or_io_data, src 2 -> opcplus4.
REQ-015 At acceptance with src 2, the stored destination SHALL be 31 regardless of req_dst.
REQ-016 An accepted request whose effective destination is 0 SHALL be consumed (handshake completes) but not enqueued.
REQ-017 The queue SHALL be FIFO; writes SHALL leave in acceptance order.
REQ-018 On each rising edge with the queue non-empty and wb_hold=0, the head SHALL be popped and loaded into wb_dst/wb_data with wb_regWrite<=1.
REQ-019 On any other rising edge, wb_regWrite SHALL load 0, and wb_dst/wb_data SHALL hold their values.
REQ-020 Minimum latency SHALL be two edges: accept at edge N, wb_regWrite=1 after edge N+1.
REQ-021 An enqueue into an empty queue SHALL not bypass; the write SHALL be popped no earlier than the following edge.
REQ-022 Simultaneous enqueue and pop SHALL leave the occupancy unchanged; on a full queue, enqueue SHALL be blocked by REQ-013 even when a pop occurs.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a counter of width log2(DEPTH)+1.
REQ-024 pend_mask SHALL be combinational from the valid queue entries only; it SHALL exclude the entry already on wb_*.
REQ-025 Two queued entries with the same destination SHALL both be written, in order, with the last write winning in the register file.

Reset
REQ-026 While reset=0 at a rising edge, the occupancy and both pointers SHALL be cleared, and wb_regWrite, wb_dst and wb_data SHALL be cleared to 0.
REQ-027 While reset=0, req_ready SHALL be 0 and pend_mask SHALL be 0.
REQ-028 A reset asserted mid-operation SHALL discard all queued entries without issuing them.
REQ-029 The first acceptance SHALL be possible on the first edge with reset=1.

Structure
REQ-030 Package wb_pkg SHALL hold the req_src encodings (SRC_ALU, SRC_MEM, SRC_JAL), the constant RA_REG=31, and the DEPTH default.
REQ-031 Storage and pointers SHALL be a sub-module wb_fifo (DEPTH x 37 bits: dst and data), exposing per-entry valid and dst for pend_mask.
REQ-032 Source muxing, Jal override, r0 drop and the output register SHALL live in writeback_queue.

Verification
REQ-033 Scenario 1: accept src0 dst=5 alu_result=0x1234 at edge N, wb_hold=0 -> after edge N+1, wb_regWrite=1, wb_dst=5, wb_data=0x00001234; pend_mask bit5 set only between edges N and N+1.
REQ-034 Scenario 2: src2 req_dst=7 opcplus4=0x00400008 -> wb_dst=31, wb_data=0x00400008.
REQ-035 Scenario 3: src0 dst=0 -> req_ready=1 and the request is consumed, no wb_regWrite pulse follows, and pend_mask stays 0.
REQ-036 Scenario 4: wb_hold=1 with 5 back-to-back requests (DEPTH=4) -> req_ready drops after the 4th acceptance; releasing wb_hold yields writes to dst 1,2,3,4, then 5 in order.
REQ-037 Scenario 5: queue full with hold released and req_valid=1 -> a pop occurs and no enqueue that edge; the enqueue occurs on the next edge.
REQ-038 Scenario 6: 3 entries queued, reset=0 for one edge -> wb_regWrite=0, pend_mask=0, and no queued write is ever issued.
